// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) memory arbiter with round-robin tie-break and a
// fixed-latency single-outstanding transaction to a combinational memory port.
module mem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_inst,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_addr,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [63:0] mem_raddr,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = 8;
  localparam logic        GRANT_IFU = 1'b0;
  localparam logic        GRANT_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IFU_BUSY = 2'd1,
    ST_LSU_BUSY = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_last_grant;
  logic                w_last_grant_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic                w_ready;
  logic                w_grant_ifu;
  logic                w_grant_lsu;

  // Ready is masked by rst_n so it reads 0 while reset is held.
  assign w_ready       = rst_n && (r_state == ST_IDLE);
  assign ifu_req_ready = w_ready;
  assign lsu_req_ready = w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= GRANT_IFU;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Arbitration, wait countdown and response-cycle memory/response drive.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    w_grant_ifu      = 1'b0;
    w_grant_lsu      = 1'b0;
    ifu_resp_valid   = 1'b0;
    ifu_inst         = '0;
    lsu_resp_valid   = 1'b0;
    lsu_rdata        = '0;
    mem_ren          = 1'b0;
    mem_wen          = 1'b0;
    mem_raddr        = '0;
    mem_waddr        = '0;
    mem_wdata        = '0;
    mem_wmask        = '0;
    case (r_state)
      ST_IDLE: begin
        if (lsu_req_valid && (!ifu_req_valid || (r_last_grant == GRANT_IFU))) begin
          w_grant_lsu      = 1'b1;
          w_state_nxt      = ST_LSU_BUSY;
          w_cnt_nxt        = CNT_W'(LATENCY - 1);
          w_last_grant_nxt = GRANT_LSU;
        end else if (ifu_req_valid) begin
          w_grant_ifu      = 1'b1;
          w_state_nxt      = ST_IFU_BUSY;
          w_cnt_nxt        = CNT_W'(LATENCY - 1);
          w_last_grant_nxt = GRANT_IFU;
        end
      end
      ST_IFU_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          mem_ren        = 1'b1;
          mem_raddr      = r_addr;
          ifu_resp_valid = 1'b1;
          ifu_inst       = r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_LSU_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          lsu_resp_valid = 1'b1;
          w_state_nxt    = ST_IDLE;
          if (r_wen) begin
            mem_wen   = 1'b1;
            mem_waddr = r_addr;
            mem_wdata = r_wdata;
            mem_wmask = r_wmask;
          end else begin
            mem_ren   = 1'b1;
            mem_raddr = r_addr;
            lsu_rdata = mem_rdata;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request payload captured at acceptance; held until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_grant_lsu) begin
      r_addr  <= lsu_addr;
      r_wen   <= lsu_wen;
      r_wdata <= lsu_wdata;
      r_wmask <= lsu_wmask;
    end else if (w_grant_ifu) begin
      r_addr  <= ifu_addr;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances at LATENCY 1, 3 and 4,
// each driven by its own stimulus slice and checked against fixed values.
module tb_mem_arbiter;

  localparam int unsigned N_DUT = 3;

  logic        clk;
  logic        rst_n          [N_DUT];
  logic        ifu_req_valid  [N_DUT];
  logic        ifu_req_ready  [N_DUT];
  logic [63:0] ifu_addr       [N_DUT];
  logic        ifu_resp_valid [N_DUT];
  logic [31:0] ifu_inst       [N_DUT];
  logic        lsu_req_valid  [N_DUT];
  logic        lsu_req_ready  [N_DUT];
  logic        lsu_wen        [N_DUT];
  logic [63:0] lsu_addr       [N_DUT];
  logic [63:0] lsu_wdata      [N_DUT];
  logic [7:0]  lsu_wmask      [N_DUT];
  logic        lsu_resp_valid [N_DUT];
  logic [63:0] lsu_rdata      [N_DUT];
  logic        mem_ren        [N_DUT];
  logic        mem_wen        [N_DUT];
  logic [63:0] mem_raddr      [N_DUT];
  logic [63:0] mem_waddr      [N_DUT];
  logic [63:0] mem_wdata      [N_DUT];
  logic [7:0]  mem_wmask      [N_DUT];
  logic [63:0] mem_rdata      [N_DUT];

  int n_tests;
  int n_fail;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    mem_arbiter #(
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n[g]),
      .ifu_req_valid  (ifu_req_valid[g]),
      .ifu_req_ready  (ifu_req_ready[g]),
      .ifu_addr       (ifu_addr[g]),
      .ifu_resp_valid (ifu_resp_valid[g]),
      .ifu_inst       (ifu_inst[g]),
      .lsu_req_valid  (lsu_req_valid[g]),
      .lsu_req_ready  (lsu_req_ready[g]),
      .lsu_wen        (lsu_wen[g]),
      .lsu_addr       (lsu_addr[g]),
      .lsu_wdata      (lsu_wdata[g]),
      .lsu_wmask      (lsu_wmask[g]),
      .lsu_resp_valid (lsu_resp_valid[g]),
      .lsu_rdata      (lsu_rdata[g]),
      .mem_ren        (mem_ren[g]),
      .mem_wen        (mem_wen[g]),
      .mem_raddr      (mem_raddr[g]),
      .mem_waddr      (mem_waddr[g]),
      .mem_wdata      (mem_wdata[g]),
      .mem_wmask      (mem_wmask[g]),
      .mem_rdata      (mem_rdata[g])
    );
  end

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      rst_n[i]         = 1'b0;
      ifu_req_valid[i] = 1'b0;
      ifu_addr[i]      = '0;
      lsu_req_valid[i] = 1'b0;
      lsu_wen[i]       = 1'b0;
      lsu_addr[i]      = '0;
      lsu_wdata[i]     = '0;
      lsu_wmask[i]     = '0;
      mem_rdata[i]     = 64'h1111_2222_3333_4444;
    end

    // Reset state
    #2;
    for (int i = 0; i < N_DUT; i++) begin
      check_eq("rst_ifu_ready", 64'(ifu_req_ready[i]), 64'd0);
      check_eq("rst_lsu_ready", 64'(lsu_req_ready[i]), 64'd0);
      check_eq("rst_mem_ren",   64'(mem_ren[i]),       64'd0);
      check_eq("rst_mem_wen",   64'(mem_wen[i]),       64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) rst_n[i] = 1'b1;
    #1;
    for (int i = 0; i < N_DUT; i++) check_eq("post_rst_ready", 64'(ifu_req_ready[i]), 64'd1);

    // LATENCY=1 IFU fetch, upper word selected by addr[2]
    @(negedge clk);
    ifu_req_valid[0] = 1'b1;
    ifu_addr[0]      = 64'h8000_0004;
    @(negedge clk);
    ifu_req_valid[0] = 1'b0;
    ifu_addr[0]      = '0;
    check_eq("ifu_resp_valid", 64'(ifu_resp_valid[0]), 64'd1);
    check_eq("ifu_inst",       64'(ifu_inst[0]),       64'h1111_2222);
    check_eq("ifu_mem_ren",    64'(mem_ren[0]),        64'd1);
    check_eq("ifu_mem_raddr",  mem_raddr[0],           64'h8000_0004);
    check_eq("ifu_busy_ready", 64'(ifu_req_ready[0]),  64'd0);
    @(negedge clk);
    check_eq("ifu_after_resp", 64'(ifu_resp_valid[0]), 64'd0);
    check_eq("ifu_after_inst", 64'(ifu_inst[0]),       64'd0);
    check_eq("ifu_after_ren",  64'(mem_ren[0]),        64'd0);
    check_eq("ifu_after_rdy",  64'(ifu_req_ready[0]),  64'd1);

    // Both valid: LSU first, then strict alternation
    ifu_req_valid[0] = 1'b1;
    ifu_addr[0]      = 64'h8000_0000;
    lsu_req_valid[0] = 1'b1;
    lsu_wen[0]       = 1'b0;
    lsu_addr[0]      = 64'h8000_3000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("rr_lsu_resp", 64'(lsu_resp_valid[0]), (k % 2 == 0) ? 64'd1 : 64'd0);
      check_eq("rr_ifu_resp", 64'(ifu_resp_valid[0]), (k % 2 == 1) ? 64'd1 : 64'd0);
      check_eq("rr_raddr",    mem_raddr[0], (k % 2 == 0) ? 64'h8000_3000 : 64'h8000_0000);
      check_eq("rr_lsu_rdata", lsu_rdata[0], (k % 2 == 0) ? 64'h1111_2222_3333_4444 : 64'd0);
      check_eq("rr_ifu_inst", 64'(ifu_inst[0]), (k % 2 == 1) ? 64'h3333_4444 : 64'd0);
      @(negedge clk);
      check_eq("rr_idle_ready", 64'(lsu_req_ready[0]), 64'd1);
    end
    ifu_req_valid[0] = 1'b0;
    lsu_req_valid[0] = 1'b0;

    // Address latched at acceptance; later input change ignored
    @(negedge clk);
    lsu_req_valid[0] = 1'b1;
    lsu_addr[0]      = 64'h8000_2000;
    @(negedge clk);
    lsu_req_valid[0] = 1'b0;
    lsu_addr[0]      = 64'hFFFF_0000;
    #1;
    check_eq("latch_raddr", mem_raddr[0], 64'h8000_2000);
    check_eq("latch_resp",  64'(lsu_resp_valid[0]), 64'd1);

    // LATENCY=3 store: single mem_wen pulse on the third cycle
    mem_rdata[1]     = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    lsu_req_valid[1] = 1'b1;
    lsu_wen[1]       = 1'b1;
    lsu_addr[1]      = 64'h8000_1000;
    lsu_wdata[1]     = 64'hDEAD_BEEF;
    lsu_wmask[1]     = 8'h0F;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_eq("st_ready",  64'(lsu_req_ready[1]),  (c == 4) ? 64'd1 : 64'd0);
      check_eq("st_wen",    64'(mem_wen[1]),        (c == 3) ? 64'd1 : 64'd0);
      check_eq("st_ren",    64'(mem_ren[1]),        64'd0);
      check_eq("st_resp",   64'(lsu_resp_valid[1]), (c == 3) ? 64'd1 : 64'd0);
      check_eq("st_waddr",  mem_waddr[1],           (c == 3) ? 64'h8000_1000 : 64'd0);
      check_eq("st_wdata",  mem_wdata[1],           (c == 3) ? 64'hDEAD_BEEF : 64'd0);
      check_eq("st_wmask",  64'(mem_wmask[1]),      (c == 3) ? 64'h0F : 64'd0);
      check_eq("st_rdata",  lsu_rdata[1],           64'd0);
      lsu_req_valid[1] = 1'b0;
      lsu_addr[1]      = 64'h1234;
      lsu_wdata[1]     = 64'h5678;
      lsu_wmask[1]     = 8'hF0;
    end

    // LATENCY=4 store aborted by reset two cycles after acceptance
    @(negedge clk);
    lsu_req_valid[2] = 1'b1;
    lsu_wen[2]       = 1'b1;
    lsu_addr[2]      = 64'h8000_4000;
    lsu_wdata[2]     = 64'h55;
    lsu_wmask[2]     = 8'hFF;
    @(negedge clk);
    lsu_req_valid[2] = 1'b0;
    lsu_wen[2]       = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check_eq("abort_ready_in_rst", 64'(lsu_req_ready[2]), 64'd0);
    check_eq("abort_wen_in_rst",   64'(mem_wen[2]),       64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("abort_rst_wen",  64'(mem_wen[2]),        64'd0);
      check_eq("abort_rst_resp", 64'(lsu_resp_valid[2]), 64'd0);
    end
    rst_n[2] = 1'b1;
    #1;
    check_eq("abort_release_ready", 64'(lsu_req_ready[2]), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("abort_wen",   64'(mem_wen[2]),        64'd0);
      check_eq("abort_resp",  64'(lsu_resp_valid[2]), 64'd0);
      check_eq("abort_ready", 64'(lsu_req_ready[2]),  64'd1);
    end

    // Pointer reset to IFU: LSU wins the first conflict, response after 4 cycles
    ifu_req_valid[2] = 1'b1;
    ifu_addr[2]      = 64'h8000_0008;
    lsu_req_valid[2] = 1'b1;
    lsu_addr[2]      = 64'h8000_5000;
    @(negedge clk);
    ifu_req_valid[2] = 1'b0;
    lsu_req_valid[2] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      check_eq("lat4_lsu_resp", 64'(lsu_resp_valid[2]), (c == 4) ? 64'd1 : 64'd0);
      check_eq("lat4_ifu_resp", 64'(ifu_resp_valid[2]), 64'd0);
      check_eq("lat4_ren",      64'(mem_ren[2]),        (c == 4) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    check_eq("lat4_idle_ready", 64'(ifu_req_ready[2]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 1, meaning cycles from request acceptance to response; legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ifu_req_valid  input  1  instruction fetch request.
REQ-005 ifu_req_ready  output  1  arbiter can accept a request this cycle (shared by both requesters).
REQ-006 ifu_addr  input  64  fetch address.
REQ-007 ifu_resp_valid  output  1  one-cycle pulse, ifu_inst valid.
REQ-008 ifu_inst  output  32  fetched instruction.
REQ-009 lsu_req_valid  input  1  load/store request.
REQ-010 lsu_req_ready  output  1  same value as ifu_req_ready.
REQ-011 lsu_wen  input  1  1 = store, 0 = load.
REQ-012 lsu_addr  input  64  data address.
REQ-013 lsu_wdata  input  64  store data.
REQ-014 lsu_wmask  input  8  store byte mask.
REQ-015 lsu_resp_valid  output  1  one-cycle pulse, load data valid or store done.
REQ-016 lsu_rdata  output  64  load data.
REQ-017 mem_ren, mem_wen  output  1 each  memory port read/write enables.
REQ-018 mem_raddr, mem_waddr  output  64 each  memory port addresses.
REQ-019 mem_wdata  output  64; mem_wmask  output  8  store data and byte mask.
REQ-020 mem_rdata  input  64  combinational read data for mem_raddr.

Function
REQ-021 States IDLE, IFU_BUSY, LSU_BUSY; ready = 1 only in IDLE.
REQ-022 A request is accepted on a rising edge where ready=1 and its valid=1; at most one acceptance per edge.
REQ-023 Both valid in IDLE: winner is the requester not granted last; 1-bit last_grant pointer updated on every acceptance.
REQ-024 Single valid in IDLE: that requester wins regardless of pointer.
REQ-025 On acceptance, latch address, wen, wdata, wmask into internal registers; later input changes ignored until next acceptance.
REQ-026 Accept moves IDLE->IFU_BUSY or LSU_BUSY and loads a 4-bit wait counter with LATENCY-1.
REQ-027 Busy state with counter > 0: decrement, all mem_* enables 0, no response.
REQ-028 Busy state with counter = 0 is the response cycle; next edge returns to IDLE.
REQ-029 IFU response cycle: mem_ren=1, mem_raddr=latched addr, ifu_resp_valid=1, ifu_inst = latched addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
REQ-030 LSU load response cycle: mem_ren=1, mem_raddr=latched addr, lsu_resp_valid=1, lsu_rdata=mem_rdata unmodified.
REQ-031 LSU store response cycle: mem_wen=1, mem_waddr, mem_wdata, mem_wmask = latched values, mem_ren=0, lsu_resp_valid=1, lsu_rdata=0.
REQ-032 mem_ren and mem_wen never both 1; both 0 outside response cycles.
REQ-033 Outside response cycles mem_raddr, mem_waddr, mem_wdata, mem_wmask, ifu_inst, lsu_rdata are 0.
REQ-034 Response pulses have no backpressure; requesters always consume them.
REQ-035 Throughput: one transaction per LATENCY+1 cycles; a request arriving in a response cycle waits, accepted on the edge after return to IDLE.
REQ-036 Addresses pass unmodified; no alignment check or fault generation.

Reset
REQ-037 rst_n=0 immediately forces IDLE, counter 0, last_grant = IFU (so LSU wins first conflict), latched registers 0.
REQ-038 During reset all outputs 0 except ready signals, which are 0 while rst_n=0 and 1 from the first cycle after release.
REQ-039 Reset asserted mid-transaction aborts it: no response pulse, no memory write issued.

Verification
REQ-040 LATENCY=1, IFU req addr 0x80000004, mem_rdata 0x1111_2222_3333_4444 -> next cycle ifu_resp_valid=1, ifu_inst=0x11112222, mem_ren=1.
REQ-041 LATENCY=1, IFU and LSU valid together after reset -> LSU served first, IFU next; repeat -> order alternates LSU, IFU, LSU, IFU.
REQ-042 LATENCY=3, LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> mem_wen pulses exactly once 3 cycles after acceptance with those values; ready low for 3 cycles.
REQ-043 LATENCY=1, change lsu_addr after acceptance -> mem_raddr in response cycle equals originally accepted address.
REQ-044 LATENCY=4, drop rst_n 2 cycles after store acceptance -> mem_wen never asserted, no resp pulse, ready=1 first cycle after release.
